// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-cache port, decode redirect requests and IF/ID register outputs of the fetch stage.
interface instr_fetch_if #(parameter int ADDR_W = 30);
   logic              icache_ren;
   logic [ADDR_W-1:0] icache_addr;
   logic [31:0]       icache_rdata;
   logic              icache_stall;
   logic              id_stall;
   logic              redir_branch;
   logic              redir_jump;
   logic              redir_jr;
   logic [ADDR_W-1:0] redir_pc1;
   logic [15:0]       redir_imm;
   logic [25:0]       redir_jidx;
   logic [31:0]       redir_jr_tgt;
   logic              if_valid;
   logic [31:0]       if_instr;
   logic [ADDR_W-1:0] if_pc1;
   modport master (
      output icache_ren, icache_addr, if_valid, if_instr, if_pc1,
      input  icache_rdata, icache_stall, id_stall, redir_branch, redir_jump,
             redir_jr, redir_pc1, redir_imm, redir_jidx, redir_jr_tgt
   );
   modport slave (
      input  icache_ren, icache_addr, if_valid, if_instr, if_pc1,
      output icache_rdata, icache_stall, id_stall, redir_branch, redir_jump,
             redir_jr, redir_pc1, redir_imm, redir_jidx, redir_jr_tgt
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage; holds the PC, reads the I-cache and fills IF/ID,
// redirecting on JR/J/taken-branch and draining an outstanding miss before a redirect takes effect.
module instr_fetch #(
   parameter int                ADDR_W   = 30,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   instr_fetch_if.master bus
);
   typedef enum logic {RUN, DRAIN} state_t;
   state_t            state, state_d;
   logic [ADDR_W-1:0] pc, pc_d, pend_pc, pend_d, pc1, pc1_d, target;
   logic [31:0]       instr, instr_d;
   logic              valid, valid_d, redir;
   logic              unused_jr_lsbs;
   assign unused_jr_lsbs = ^bus.redir_jr_tgt[1:0];
   assign redir = bus.redir_jr | bus.redir_jump | bus.redir_branch;
   always_comb
      target = bus.redir_jr   ? bus.redir_jr_tgt[ADDR_W+1:2] :
               bus.redir_jump ? {bus.redir_pc1[ADDR_W-1:26], bus.redir_jidx} :
                                bus.redir_pc1 + {{(ADDR_W-16){bus.redir_imm[15]}}, bus.redir_imm};
   always_comb begin
      state_d = state;
      pc_d    = pc;
      pend_d  = pend_pc;
      valid_d = valid;
      instr_d = instr;
      pc1_d   = pc1;
      if (state == DRAIN) begin
         // the miss data belongs to the wrong path, so it is dropped
         valid_d = 1'b0;
         if (!bus.icache_stall) begin
            pc_d    = pend_pc;
            state_d = RUN;
         end
      end else if (redir) begin
         valid_d = 1'b0;
         if (bus.icache_stall) begin
            pend_d  = target;
            state_d = DRAIN;
         end else begin
            pc_d    = target;
            instr_d = '0;
         end
      end else if (bus.icache_stall) begin
         valid_d = bus.id_stall & valid;
      end else if (!bus.id_stall) begin
         instr_d = bus.icache_rdata;
         pc1_d   = pc + ADDR_W'(1);
         valid_d = 1'b1;
         pc_d    = pc + ADDR_W'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         pc      <= RESET_PC;
         pend_pc <= '0;
         valid   <= 1'b0;
         instr   <= '0;
         pc1     <= '0;
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         pend_pc <= pend_d;
         valid   <= valid_d;
         instr   <= instr_d;
         pc1     <= pc1_d;
      end
   end
   assign bus.icache_ren  = ~rst;
   assign bus.icache_addr = pc;
   assign bus.if_valid    = valid;
   assign bus.if_instr    = instr;
   assign bus.if_pc1      = pc1;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus against a cycle model of the fetch stage, with literal checks on key cycles.
module tb_instr_fetch;
   localparam int AW = 30;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0, fails = 0;
   instr_fetch_if #(.ADDR_W(AW)) bus ();
   instr_fetch #(.ADDR_W(AW), .RESET_PC('0)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] word(input logic [AW-1:0] a);
      return {2'b10, a};
   endfunction
   assign bus.icache_rdata = word(bus.icache_addr);
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   // model state: pc being fetched, optional deferred target, IF/ID contents
   logic [AW-1:0] m_pc, m_pend, m_pc1;
   logic [31:0]   m_instr;
   bit            m_pending, m_valid, m_init = 0;
   function automatic logic [AW-1:0] tgt();
      longint mask = (longint'(1) << AW) - 1;
      if (bus.redir_jr) return AW'(bus.redir_jr_tgt >> 2);
      if (bus.redir_jump) return AW'((longint'(bus.redir_pc1) & ~longint'(32'h03FF_FFFF)) | longint'(bus.redir_jidx));
      return AW'((longint'(bus.redir_pc1) + longint'($signed(bus.redir_imm))) & mask);
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         m_init = 1; m_pc = '0; m_pending = 0; m_valid = 0; m_instr = '0; m_pc1 = '0;
      end else if (m_pending) begin
         m_valid = 0;
         if (!bus.icache_stall) begin m_pc = m_pend; m_pending = 0; end
      end else if (bus.redir_jr || bus.redir_jump || bus.redir_branch) begin
         m_valid = 0;
         if (bus.icache_stall) begin m_pending = 1; m_pend = tgt(); end
         else begin m_pc = tgt(); m_instr = '0; end
      end else if (bus.icache_stall) begin
         if (!bus.id_stall) m_valid = 0;
      end else if (!bus.id_stall) begin
         m_instr = word(m_pc); m_pc1 = m_pc + 1; m_valid = 1; m_pc = m_pc + 1;
      end
   end
   always @(negedge clk) if (m_init) begin
      chk("ren", 32'(bus.icache_ren), 32'(!rst));
      chk("addr", 32'(bus.icache_addr), 32'(m_pc));
      chk("valid", 32'(bus.if_valid), 32'(m_valid));
      if (m_valid) begin
         chk("instr", bus.if_instr, m_instr);
         chk("pc1", 32'(bus.if_pc1), 32'(m_pc1));
      end
   end
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask
   task automatic clr();
      bus.redir_branch = 0; bus.redir_jump = 0; bus.redir_jr = 0;
   endtask
   initial begin
      rst = 1; clr();
      bus.icache_stall = 0; bus.id_stall = 0; bus.redir_pc1 = '0; bus.redir_imm = '0;
      bus.redir_jidx = '0; bus.redir_jr_tgt = '0;
      tick(2);
      chk("rst_valid", 32'(bus.if_valid), 0);
      chk("rst_instr", bus.if_instr, 0);
      chk("rst_pc1", 32'(bus.if_pc1), 0);
      rst = 0;
      #1 chk("t1_addr0", 32'(bus.icache_addr), 0);
      chk("t1_ren", 32'(bus.icache_ren), 1);
      tick(1);
      chk("t1_addr1", 32'(bus.icache_addr), 1);
      chk("t1_valid", 32'(bus.if_valid), 1);
      chk("t1_instr", bus.if_instr, 32'h8000_0000);
      chk("t1_pc1", 32'(bus.if_pc1), 1);
      tick(1); chk("t1_addr2", 32'(bus.icache_addr), 2);
      tick(1); chk("t1_addr3", 32'(bus.icache_addr), 3);
      tick(2);
      bus.icache_stall = 1;
      tick(3);
      chk("t2_addr_held", 32'(bus.icache_addr), 5);
      chk("t2_bubble", 32'(bus.if_valid), 0);
      bus.icache_stall = 0;
      tick(1);
      chk("t2_instr", bus.if_instr, 32'h8000_0005);
      chk("t2_pc1", 32'(bus.if_pc1), 6);
      bus.redir_branch = 1; bus.redir_pc1 = 30'h10; bus.redir_imm = 16'hFFFC;
      tick(1); clr();
      chk("t3_br_addr", 32'(bus.icache_addr), 32'h0C);
      chk("t3_br_bubble", 32'(bus.if_valid), 0);
      tick(1);
      chk("t3_br_instr", bus.if_instr, 32'h8000_000C);
      bus.redir_branch = 1; bus.redir_pc1 = '0; bus.redir_imm = 16'hFFFF;
      tick(1); clr();
      chk("t3_wrap", 32'(bus.icache_addr), 32'h3FFF_FFFF);
      tick(1);
      chk("t3_pc_wrap", 32'(bus.icache_addr), 0);
      chk("t3_pc1_wrap", 32'(bus.if_pc1), 0);
      tick(8);
      bus.icache_stall = 1; bus.redir_jump = 1; bus.redir_jidx = 26'h40; bus.redir_pc1 = 30'h9;
      tick(1); clr();
      chk("t4_drain_addr", 32'(bus.icache_addr), 8);
      bus.redir_branch = 1; bus.redir_pc1 = 30'h100; bus.redir_imm = '0;
      tick(2); clr();
      chk("t4_drain_held", 32'(bus.icache_addr), 8);
      chk("t4_drain_valid", 32'(bus.if_valid), 0);
      bus.icache_stall = 0;
      tick(1);
      chk("t4_jump_addr", 32'(bus.icache_addr), 32'h40);
      chk("t4_discard", 32'(bus.if_valid), 0);
      tick(1);
      chk("t4_instr", bus.if_instr, 32'h8000_0040);
      bus.id_stall = 1;
      tick(2);
      chk("t5_hold_instr", bus.if_instr, 32'h8000_0040);
      chk("t5_hold_addr", 32'(bus.icache_addr), 32'h41);
      chk("t5_hold_valid", 32'(bus.if_valid), 1);
      bus.id_stall = 0;
      tick(1);
      chk("t5_resume", bus.if_instr, 32'h8000_0041);
      chk("t5_resume_pc1", 32'(bus.if_pc1), 32'h42);
      bus.redir_jr = 1; bus.redir_jr_tgt = 32'h103; bus.redir_jump = 1; bus.redir_jidx = 26'h80;
      bus.redir_branch = 1; bus.redir_imm = 16'h5;
      tick(1); clr();
      chk("t6_jr_wins", 32'(bus.icache_addr), 32'h40);
      tick(2);
      bus.icache_stall = 1; bus.redir_branch = 1; bus.redir_pc1 = 30'h20; bus.redir_imm = '0;
      tick(1); clr();
      rst = 1;
      #1 chk("t6_ren_rst", 32'(bus.icache_ren), 0);
      tick(1);
      rst = 0; bus.icache_stall = 0;
      chk("t6_rst_addr", 32'(bus.icache_addr), 0);
      chk("t6_rst_valid", 32'(bus.if_valid), 0);
      tick(3);
      chk("t6_after_rst", 32'(bus.icache_addr), 3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the single-issue MIPS pipeline.
- Drives the instruction-cache read port and holds the PC.
- Presents one instruction per cycle in the IF/ID register to the opcode decoder.
- Consumes the decoder's control-flow results (Branch-taken, Jump, isJR) as redirect requests: computes the target, flushes the wrong-path slot, and restarts fetch.

Parameters:
ADDR_W, 30, word-address width of the PC and the instruction-cache address (byte address = {pc, 2'b00}).
RESET_PC, 0, word address fetched first after reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
icache_ren  output  1  instruction-cache read enable.
icache_addr  output  ADDR_W  word address being read.
icache_rdata  input  32  instruction word; valid in any cycle with icache_ren=1 and icache_stall=0.
icache_stall  input  1  cache miss in progress; address must be held stable while high.
id_stall  input  1  hazard hold from decode; IF/ID and PC must not advance.
redir_branch  input  1  branch resolved taken (Branch and condition true).
redir_jump  input  1  J/JAL in decode.
redir_jr  input  1  JR in decode (isJR).
redir_pc1  input  ADDR_W  PC+1 of the redirecting instruction.
redir_imm  input  16  branch offset, in words.
redir_jidx  input  26  jump index field.
redir_jr_tgt  input  32  rs register value (byte address).
if_valid  output  1  IF/ID holds a real instruction.
if_instr  output  32  IF/ID instruction.
if_pc1  output  ADDR_W  IF/ID PC+1, used as the JAL link and branch base.

Behaviour:
Reset (rst=1 at the clock edge):
- pc=RESET_PC, state=RUN, if_valid=0, if_instr=0 (nop), if_pc1=0, pend_pc=0.
- icache_ren=0 during any cycle with rst=1; otherwise icache_ren=1.
- Reset mid-miss aborts the request; the next access starts at RESET_PC.

Redirect target (combinational):
- Priority: redir_jr > redir_jump > redir_branch.
- JR: redir_jr_tgt[ADDR_W+1:2]; the low 2 bits are ignored.
- Jump: {redir_pc1[ADDR_W-1:26], redir_jidx}.
- Branch: redir_pc1 + sign-extended redir_imm, modulo 2^ADDR_W. Wrap-around is legal.
- redir = OR of the three redirect inputs.

States: RUN, DRAIN.
- icache_addr = pc in RUN and in DRAIN.

RUN:
- redir=1 and icache_stall=0: pc<=target, if_valid<=0, if_instr<=0, stay RUN. Redirect overrides id_stall. There is no delay slot; the fetched word is discarded.
- redir=1 and icache_stall=1: pend_pc<=target, if_valid<=0, go DRAIN.
- redir=0, icache_stall=1: hold pc and IF/ID. if_valid<=0 unless id_stall=1, in which case IF/ID holds.
- redir=0, icache_stall=0, id_stall=1: hold pc and IF/ID. The same address is re-read next cycle.
- redir=0, icache_stall=0, id_stall=0: if_instr<=icache_rdata, if_pc1<=pc+1, if_valid<=1, pc<=pc+1. pc wraps from all-ones to 0.

DRAIN:
- Holds the outstanding address stable until the cache completes.
- if_valid stays 0; further redirects are ignored because the pipeline is already flushed.
- When icache_stall=0: the returned data is discarded, pc<=pend_pc, go RUN.

Throughput and latency:
- One instruction per cycle with no stalls.
- Redirect penalty: one bubble (RUN), or bubbles for the remaining miss cycles plus one (DRAIN).

Test Plan:
1. Reset with RESET_PC=0, no stalls, rdata=addr-tagged words -> icache_addr 0,1,2,3 on consecutive cycles; if_valid=1 from the 2nd cycle; if_instr=word(0) with if_pc1=1.
2. icache_stall high 3 cycles at pc=5 -> icache_addr stays 5 for 4 cycles; if_valid=0 for 3 cycles; then if_instr=word(5), if_pc1=6.
3. Branch: redir_branch=1, redir_pc1=0x10, redir_imm=0xFFFC -> next icache_addr=0x0C; if_valid=0 for one cycle; pc=0 with imm=-1 wraps to 0x3FFFFFFF.
4. Redirect during miss: pc=8, icache_stall=1, redir_jump=1, redir_jidx=0x40 -> state DRAIN, icache_addr stays 8 until the stall drops; data discarded; then icache_addr=0x40.
5. id_stall=1 for 2 cycles -> if_instr, if_pc1, if_valid unchanged and icache_addr constant; after release the sequence resumes without skip or duplicate.
6. redir_jr=1 (tgt 0x100), redir_jump=1 and redir_branch=1 together -> next icache_addr=0x40 (JR wins); rst asserted mid-DRAIN -> next icache_addr=RESET_PC, if_valid=0.
